decoder_sel_sequencer: RTL and testbench
========================================

Name: decoder_sel_sequencer

Overview:
Upstream stage for the 3-to-8 one-hot decoder. Drives the decoder's three select inputs (A = MSB, C = LSB) through the channels enabled in an 8-bit mask, in ascending code order. Holds each code for a programmable dwell time, with a start/busy/done handshake and single-pass or continuous scanning. All outputs are registered, so the decoder's one-hot output follows the sequencer combinationally.

Parameters:
DWELL, 4, cycles each code is held with VALID high; legal range 1..255
CW, 8, width of the internal dwell counter; must satisfy 2^CW > DWELL

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
START  input  1  start request; sampled in IDLE only
STOP  input  1  abort request; sampled in RUN only
CONT  input  1  continuous mode, latched at accepted START (1 = wrap to lowest enabled code after the highest)
MASK  input  8  channel enable, bit n = code n; latched at accepted START
A  output  1  select bit 2 (MSB) to decoder
B  output  1  select bit 1 to decoder
C  output  1  select bit 0 (LSB) to decoder
VALID  output  1  {A,B,C} is a live channel select
STEP  output  1  one-cycle pulse on the first cycle of each new code
BUSY  output  1  high while in RUN
DONE  output  1  one-cycle pulse on normal pass completion

Behaviour:
- Reset: state IDLE; A=B=C=0, VALID=0, STEP=0, BUSY=0, DONE=0, dwell counter=0, latched mask=0, latched CONT=0. RST has priority over all inputs.
- States: IDLE, RUN. DONE is a pulse, not a state.
- IDLE:
  - START=1 and MASK!=0: latch MASK and CONT. Next cycle: state RUN, {A,B,C} = lowest set bit index of MASK, VALID=1, STEP=1, BUSY=1, counter=1.
  - START=1 and MASK==0: stay IDLE. DONE=1 for the next cycle only; VALID stays 0.
  - STOP is ignored in IDLE.
- RUN, dwell:
  - Each code is held for exactly DWELL cycles with VALID=1.
  - Counter runs 1..DWELL. While counter < DWELL, increment it.
- RUN, end of dwell (counter == DWELL):
  - A higher set bit exists in the latched mask: load the next higher set index, counter=1, STEP=1.
  - No higher bit and latched CONT=1: wrap to the lowest set index, counter=1, STEP=1. A single-bit mask re-selects the same code with STEP=1.
  - No higher bit and latched CONT=0: next cycle state IDLE, VALID=0, BUSY=0, DONE=1, {A,B,C} return to 0.
- Back-to-back codes: no gap. VALID stays continuously high across code changes; code changes are only visible via STEP.
- STOP in RUN, in any cycle: next cycle state IDLE, VALID=0, BUSY=0, DONE=0, {A,B,C}=0. STOP outranks end-of-dwell advance.
- START while BUSY is ignored. MASK and CONT changes while BUSY have no effect until the next accepted START.
- START is accepted only when BUSY=0. START in the same cycle as the DONE pulse (state IDLE) is accepted normally.
- DONE and STEP are never high in the same cycle. VALID=0 implies STEP=0.
- RST mid-scan: outputs return to their reset values on the next edge. No DONE pulse.
- Pass latency: popcount(MASK) x DWELL cycles from the first STEP to the DONE cycle.

Optional Feature:
Macro DECSEQ_PASS_CNT_EN.
- Defined: adds output PASS_CNT [7:0], reset to 0 by RST and cleared at each accepted START.
  - Increments on every pass completion: the wrap event in continuous mode, or the DONE cycle in single-pass mode.
  - Saturates at 255.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: RST high for 2 cycles, then low, START=0 -> A,B,C,VALID,STEP,BUSY,DONE all 0 for 10 cycles.
- Single pass: DWELL=4, MASK=8'b1010_0101, CONT=0, START pulse -> codes 0,2,5,7 each held 4 cycles with STEP on each first cycle; BUSY high 16 cycles; DONE pulse on cycle 17 after START; VALID=0 after.
- Empty mask: MASK=0, START -> DONE=1 exactly one cycle later; VALID, BUSY, STEP stay 0.
- Continuous wrap: MASK=8'b1000_0001, CONT=1, DWELL=2 -> sequence 0,0,7,7,0,0,7,7...; no DONE. STOP at an arbitrary cycle -> VALID=0 and BUSY=0 next cycle, DONE stays 0.
- Ignored inputs: during a scan with MASK=8'h0F, drive START=1 and MASK=8'hF0 -> scan continues over codes 0..3 only, then DONE.
- Reset mid-scan and DWELL=1 corner: DWELL=1, MASK=8'hFF, CONT=0 -> code increments every cycle 0..7 with STEP high 8 consecutive cycles, then DONE. Repeat with RST asserted at code 3 -> all outputs 0 next cycle, no DONE.

Source files
------------

// File: rtl/decoder_sel_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_sel_sequencer
//
// Purpose:
//   Upstream stage for a 3-to-8 one-hot decoder. Walks the decoder select
//   lines {A,B,C} (A = MSB) through every channel enabled in an 8-bit mask,
//   in ascending code order. Each code is held for DWELL cycles. A
//   start/busy/done handshake controls the scan. The scan is either a single
//   pass or continuous (wraps to the lowest enabled code). All outputs come
//   straight from flops, so a decoder placed downstream sees glitch-free
//   selects.
//
// Parameters:
//   DWELL  cycles each code is held with VALID high (1..255)
//   CW     dwell counter width, 2**CW must exceed DWELL
//
// Ports:
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset, highest priority
//   START     in   start request, sampled in IDLE only
//   STOP      in   abort request, sampled in RUN only
//   CONT      in   continuous mode, latched at an accepted START
//   MASK[7:0] in   channel enables (bit n = code n), latched at an accepted START
//   A,B,C     out  decoder select, A = bit 2, C = bit 0
//   VALID     out  {A,B,C} is a live channel select
//   STEP      out  one-cycle pulse on the first cycle of each new code
//   BUSY      out  high while a scan is running
//   DONE      out  one-cycle pulse on normal pass completion (or empty-mask START)
//   PASS_CNT  out  [7:0] saturating count of completed passes
//                  (present only with DECSEQ_PASS_CNT_EN)
//
// Build option:
//   DECSEQ_PASS_CNT_EN  when defined, adds the PASS_CNT output and its counter.
// -----------------------------------------------------------------------------
module decoder_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CONT,
  input  logic [7:0] MASK,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       VALID,
  output logic       STEP,
  output logic       BUSY,
  output logic       DONE
`ifdef DECSEQ_PASS_CNT_EN
  ,
  output logic [7:0] PASS_CNT
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  // Search helper: returns {found, index} of the lowest set bit of m whose
  // index is >= from. A 'from' of 8 never matches, which is how "no higher
  // channel after code 7" falls out naturally.
  function automatic logic [3:0] first_set_from(input logic [7:0] m,
                                                input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    // Scan downward so the lowest qualifying index is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) begin
        res = {1'b1, 3'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            step_q, step_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mask_q, mask_d;
  logic            cont_q, cont_d;

  logic [3:0]      low_in_s;   // lowest enabled code of the live MASK input
  logic [3:0]      low_lat_s;  // lowest enabled code of the latched mask
  logic [3:0]      nxt_s;      // next enabled code above the current one
  logic            accept_s;
  logic            empty_s;
  logic            stop_s;
  logic            end_s;
  logic            adv_s;
  logic            wrap_s;
  logic            finish_s;

  // Scan events derived from the current state, latched mask and inputs.
  always_comb begin
    low_in_s  = first_set_from(MASK, 4'd0);
    low_lat_s = first_set_from(mask_q, 4'd0);
    nxt_s     = first_set_from(mask_q, {1'b0, code_q} + 4'd1);

    // low_in_s[3] is set exactly when MASK is non-zero.
    accept_s = (state_q == S_IDLE) && START && low_in_s[3];
    empty_s  = (state_q == S_IDLE) && START && !low_in_s[3];
    stop_s   = (state_q == S_RUN) && STOP;
    // STOP outranks every end-of-dwell action.
    end_s    = (state_q == S_RUN) && !STOP && (cnt_q == DWELL_C);
    adv_s    = end_s && nxt_s[3];
    wrap_s   = end_s && !nxt_s[3] && cont_q && low_lat_s[3];
    finish_s = end_s && !nxt_s[3] && !wrap_s;
  end

  // Next-state logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop_s || finish_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, dwell counter and latched config.
  // Everything not explicitly driven returns to its idle value.
  always_comb begin
    code_d  = 3'd0;
    valid_d = 1'b0;
    step_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = CNT_ZERO;
    mask_d  = mask_q;
    cont_d  = cont_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          mask_d  = MASK;
          cont_d  = CONT;
          code_d  = low_in_s[2:0];
          cnt_d   = CNT_ONE;
          valid_d = 1'b1;
          step_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (empty_s) begin
          // Nothing to scan: report completion immediately.
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      S_RUN: begin
        if (stop_s) begin
          // Abort: silent return to idle, no DONE.
          done_d = 1'b0;
        end else if (adv_s) begin
          code_d  = nxt_s[2:0];
          cnt_d   = CNT_ONE;
          valid_d = 1'b1;
          step_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (wrap_s) begin
          // A single-bit mask re-selects the same code, still with STEP.
          code_d  = low_lat_s[2:0];
          cnt_d   = CNT_ONE;
          valid_d = 1'b1;
          step_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (finish_s) begin
          done_d = 1'b1;
        end else begin
          // Mid-dwell: hold the code and keep counting.
          code_d  = code_q;
          cnt_d   = cnt_q + CNT_ONE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, counter and latched-configuration registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
      mask_q  <= 8'd0;
      cont_q  <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign A     = code_q[2];
  assign B     = code_q[1];
  assign C     = code_q[0];
  assign VALID = valid_q;
  assign STEP  = step_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

`ifdef DECSEQ_PASS_CNT_EN
  logic [7:0] pass_q, pass_d;

  // Pass counter: cleared at accepted START, counts wraps and normal
  // completions, sticks at 255.
  always_comb begin
    pass_d = pass_q;
    if (accept_s) begin
      pass_d = 8'd0;
    end else if ((wrap_s || finish_s) && (pass_q != 8'hFF)) begin
      pass_d = pass_q + 8'd1;
    end else begin
      pass_d = pass_q;
    end
  end

  // Pass counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pass_q <= 8'd0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign PASS_CNT = pass_q;
`endif

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
module tb_decoder_sel_sequencer;

  typedef struct packed {
    logic [2:0] code;
    logic       valid;
    logic       step;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int         inst;
    logic [7:0] mask;
    int         disturb;
    int         exp_busy;
    int         exp_steps;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start_r [3];
  logic       stop_r  [3];
  logic       cont_r  [3];
  logic [7:0] mask_r  [3];
  logic       a_w [3];
  logic       b_w [3];
  logic       c_w [3];
  logic       valid_w [3];
  logic       step_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic [6:0] obs_w [3];
`ifdef DECSEQ_PASS_CNT_EN
  logic [7:0] pc_w [3];
`endif

  int   n_total;
  int   n_bad;
  obs_t exp_q[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DWELL=4, instance 1: DWELL=2, instance 2: DWELL=1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    decoder_sel_sequencer #(
      .DWELL((g == 0) ? 4 : ((g == 1) ? 2 : 1)),
      .CW   (8)
    ) u_dut (
      .CLK  (clk),
      .RST  (rst),
      .START(start_r[g]),
      .STOP (stop_r[g]),
      .CONT (cont_r[g]),
      .MASK (mask_r[g]),
      .A    (a_w[g]),
      .B    (b_w[g]),
      .C    (c_w[g]),
      .VALID(valid_w[g]),
      .STEP (step_w[g]),
      .BUSY (busy_w[g]),
      .DONE (done_w[g])
`ifdef DECSEQ_PASS_CNT_EN
      ,
      .PASS_CNT(pc_w[g])
`endif
    );
    assign obs_w[g] = {a_w[g], b_w[g], c_w[g], valid_w[g], step_w[g], busy_w[g], done_w[g]};
  end

  function automatic int dwell_of(input int inst);
    return (inst == 0) ? 4 : ((inst == 1) ? 2 : 1);
  endfunction

  function automatic obs_t mk(input logic [2:0] code, input logic v, input logic s,
                              input logic b, input logic d);
    obs_t o;
    o.code = code; o.valid = v; o.step = s; o.busy = b; o.done = d;
    return o;
  endfunction

  // Expected cycles of one pass: every enabled code, ascending, dwell cycles each.
  task automatic push_pass(input int dw, input logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        for (int d = 0; d < dw; d++) begin
          exp_q.push_back(mk(3'(i), 1'b1, (d == 0), 1'b1, 1'b0));
        end
      end
    end
  endtask

  task automatic check_one(input int inst, input string tag);
    obs_t e;
    obs_t a;
    n_total++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s inst%0d: scoreboard empty, nothing expected", tag, inst);
    end else begin
      e = exp_q.pop_front();
      a = obs_t'(obs_w[inst]);
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s inst%0d t=%0t: got code=%0d v=%b s=%b b=%b d=%b want code=%0d v=%b s=%b b=%b d=%b",
                 tag, inst, $time, a.code, a.valid, a.step, a.busy, a.done,
                 e.code, e.valid, e.step, e.busy, e.done);
      end
    end
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int dw;
    int busy_n;
    int step_n;
    int cyc_n;
    obs_t a;
    dw = dwell_of(v.inst);
    push_pass(dw, v.mask);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_r[v.inst] = 1'b1;
    mask_r[v.inst]  = v.mask;
    cont_r[v.inst]  = 1'b0;
    busy_n = 0; step_n = 0; cyc_n = 0;
    while (exp_q.size() > 0 && cyc_n < 400) begin
      @(negedge clk);
      cyc_n++;
      a = obs_t'(obs_w[v.inst]);
      if (a.busy === 1'b1) busy_n++;
      if (a.step === 1'b1) step_n++;
      check_one(v.inst, $sformatf("vec%0d", idx));
      if (cyc_n == 1) begin
        start_r[v.inst] = 1'b0;
        mask_r[v.inst]  = 8'h00;
      end
      // Mid-scan disturbance: START plus a different MASK/CONT must be ignored.
      if (v.disturb != 0 && cyc_n == v.disturb) begin
        start_r[v.inst] = 1'b1;
        mask_r[v.inst]  = 8'hF0;
        cont_r[v.inst]  = 1'b1;
      end
      if (v.disturb != 0 && cyc_n == v.disturb + 1) begin
        start_r[v.inst] = 1'b0;
        mask_r[v.inst]  = 8'h00;
        cont_r[v.inst]  = 1'b0;
      end
    end
    if (exp_q.size() > 0) begin
      n_total++; n_bad++;
      $display("FAIL vec%0d timeout: %0d expected cycles left", idx, exp_q.size());
      exp_q.delete();
    end
    n_total++;
    if (busy_n != v.exp_busy) begin
      n_bad++;
      $display("FAIL vec%0d busy_cycles: got %0d want %0d", idx, busy_n, v.exp_busy);
    end
    n_total++;
    if (step_n != v.exp_steps) begin
      n_bad++;
      $display("FAIL vec%0d step_pulses: got %0d want %0d", idx, step_n, v.exp_steps);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0; stop_r[i] = 1'b0; cont_r[i] = 1'b0; mask_r[i] = 8'h00;
    end

    vecs[0] = '{inst: 0, mask: 8'hA5, disturb: 0, exp_busy: 16, exp_steps: 4};
    vecs[1] = '{inst: 0, mask: 8'h00, disturb: 0, exp_busy: 0,  exp_steps: 0};
    vecs[2] = '{inst: 2, mask: 8'hFF, disturb: 0, exp_busy: 8,  exp_steps: 8};
    vecs[3] = '{inst: 0, mask: 8'h0F, disturb: 3, exp_busy: 16, exp_steps: 4};
    vecs[4] = '{inst: 1, mask: 8'h80, disturb: 0, exp_busy: 2,  exp_steps: 1};
    vecs[5] = '{inst: 2, mask: 8'h01, disturb: 0, exp_busy: 1,  exp_steps: 1};
    vecs[6] = '{inst: 1, mask: 8'h5A, disturb: 0, exp_busy: 8,  exp_steps: 4};

    // Reset held for two cycles, then ten idle cycles on every instance.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        check_one(i, "reset_idle");
      end
    end

    // Table-driven single-pass scans.
    for (int v = 0; v < 7; v++) begin
      run_vector(v, vecs[v]);
    end

    // Continuous wrap on DWELL=2, mask 0x81; CONT input dropped after START.
    start_r[1] = 1'b1; mask_r[1] = 8'h81; cont_r[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(mk(((k % 4) < 2) ? 3'd0 : 3'd7, 1'b1, ((k % 2) == 0), 1'b1, 1'b0));
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_one(1, "cont_wrap");
      if (k == 0) begin
        start_r[1] = 1'b0; mask_r[1] = 8'h00; cont_r[1] = 1'b0;
      end
    end
    // STOP on an end-of-dwell cycle: abort wins, no DONE.
    stop_r[1] = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_one(1, "cont_stop");
    stop_r[1] = 1'b0;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_one(1, "cont_stop_idle");

    // START in the DONE cycle is accepted (DWELL=4).
    start_r[0] = 1'b1; mask_r[0] = 8'h01;
    push_pass(4, 8'h01);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_one(0, "b2b_first");
      if (k == 0) begin
        start_r[0] = 1'b0; mask_r[0] = 8'h00;
      end
    end
    start_r[0] = 1'b1; mask_r[0] = 8'h02;
    push_pass(4, 8'h02);
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_one(0, "b2b_second");
      if (k == 0) begin
        start_r[0] = 1'b0; mask_r[0] = 8'h00;
      end
    end

    // Reset mid-scan at code 3 on DWELL=1: outputs clear, no DONE afterwards.
    start_r[2] = 1'b1; mask_r[2] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(3'(k), 1'b1, 1'b1, 1'b1, 1'b0));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_one(2, "rst_mid_scan");
      if (k == 0) begin
        start_r[2] = 1'b0; mask_r[2] = 8'h00;
      end
    end
    rst = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_one(2, "rst_mid_clear");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      check_one(2, "rst_mid_no_done");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
